// File: rtl/sseg_serial_ctrl_if.sv
// Bus between a frame producer and the serial seven-segment controller.
//
// Handshake: start is sampled only while the controller is idle (busy=0).
// A start seen in cycle k launches a frame whose inputs are snapshotted in that
// same cycle. busy rises in cycle k+1 and stays high through the latch cycle.
// done pulses for exactly one cycle in the latch cycle. A start raised while
// busy=1 is dropped, not queued.
interface sseg_serial_ctrl_if #(
  parameter int DIGITS = 8
);
  logic                  start;
  logic                  flash;
  logic [4*DIGITS-1:0]   hexs;
  logic [DIGITS-1:0]     les;
  logic [DIGITS-1:0]     point;
  logic                  raw_mode;
  logic [8*DIGITS-1:0]   raw_seg;
  logic                  seg_clk;
  logic                  seg_clrn;
  logic                  seg_sout;
  logic                  seg_pen;
  logic                  busy;
  logic                  done;

  modport master (
    output start, flash, hexs, les, point, raw_mode, raw_seg,
    input  seg_clk, seg_clrn, seg_sout, seg_pen, busy, done
  );

  modport slave (
    input  start, flash, hexs, les, point, raw_mode, raw_seg,
    output seg_clk, seg_clrn, seg_sout, seg_pen, busy, done
  );
endinterface

// File: rtl/sseg_serial_ctrl.sv
// Serial seven-segment display controller: encodes DIGITS hex nibbles (or raw
// bytes) into one frame and shifts it out to external shift-register drivers
// over a clock/data/clear/enable link, then pulses the latch enable.
module sseg_serial_ctrl #(
  parameter int DIGITS         = 8,
  parameter int CLK_DIV        = 2,
  parameter int MSB_FIRST      = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AUTO_PERIOD    = 0
) (
  input  logic                clk,
  input  logic                rst,
  sseg_serial_ctrl_if.slave   bus,
  output logic [1:0]          dbg_state
);

  localparam int NBITS = 8 * DIGITS;
  localparam int BW    = $clog2(NBITS);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW    = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'((AUTO_PERIOD > 0) ? AUTO_PERIOD - 1 : 0);
  localparam logic [7:0]    BLANK     = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t            state;
  logic [NBITS-1:0]  shreg;
  logic [BW-1:0]     bit_cnt;
  logic [DW-1:0]     div_cnt;
  logic [AW-1:0]     auto_cnt;
  logic              seg_clk_q;
  logic              seg_clrn_q;
  logic              seg_sout_q;
  logic              seg_pen_q;
  logic              busy_q;
  logic              done_q;

  logic [NBITS-1:0]  frame_enc;
  logic              next_bit;
  logic [NBITS-1:0]  shreg_shifted;
  logic              auto_hit;
  logic              trigger;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    hex_to_seg = 7'h3F;
      4'h1:    hex_to_seg = 7'h06;
      4'h2:    hex_to_seg = 7'h5B;
      4'h3:    hex_to_seg = 7'h4F;
      4'h4:    hex_to_seg = 7'h66;
      4'h5:    hex_to_seg = 7'h6D;
      4'h6:    hex_to_seg = 7'h7D;
      4'h7:    hex_to_seg = 7'h07;
      4'h8:    hex_to_seg = 7'h7F;
      4'h9:    hex_to_seg = 7'h6F;
      4'hA:    hex_to_seg = 7'h77;
      4'hB:    hex_to_seg = 7'h7C;
      4'hC:    hex_to_seg = 7'h39;
      4'hD:    hex_to_seg = 7'h5E;
      4'hE:    hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // Build the pin-polarity frame from the live inputs; blanking wins over both modes.
  always_comb begin
    frame_enc = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.les[i] && bus.flash) begin
        frame_enc[8*i +: 8] = BLANK;
      end else if (bus.raw_mode) begin
        frame_enc[8*i +: 8] = bus.raw_seg[8*i +: 8];
      end else if (SEG_ACTIVE_LOW != 0) begin
        frame_enc[8*i +: 8] = ~{bus.point[i], hex_to_seg(bus.hexs[4*i +: 4])};
      end else begin
        frame_enc[8*i +: 8] = {bus.point[i], hex_to_seg(bus.hexs[4*i +: 4])};
      end
    end
  end

  // Bit order is fixed by MSB_FIRST: the head of the shift register is the next bit out.
  assign next_bit      = (MSB_FIRST != 0) ? shreg[NBITS-1] : shreg[0];
  assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[NBITS-2:0], 1'b0}
                                          : {1'b0, shreg[NBITS-1:1]};

  assign auto_hit = (AUTO_PERIOD > 0) && (auto_cnt == AUTO_LAST);
  assign trigger  = bus.start || auto_hit;

  // Frame sequencer: IDLE -> LOAD -> SHIFT -> LATCH -> IDLE, all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      auto_cnt   <= '0;
      seg_clk_q  <= 1'b0;
      seg_clrn_q <= 1'b0;
      seg_sout_q <= 1'b0;
      seg_pen_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          busy_q     <= 1'b0;
          seg_clk_q  <= 1'b0;
          seg_clrn_q <= 1'b1;
          seg_sout_q <= 1'b0;
          if (trigger) begin
            // Snapshot happens here so later input changes cannot reach this frame.
            state      <= S_LOAD;
            shreg      <= frame_enc;
            auto_cnt   <= '0;
            busy_q     <= 1'b1;
            seg_clrn_q <= 1'b0;
            seg_pen_q  <= 1'b0;
          end else if (AUTO_PERIOD > 0) begin
            auto_cnt <= auto_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          state      <= S_SHIFT;
          seg_clrn_q <= 1'b1;
          seg_clk_q  <= 1'b0;
          seg_sout_q <= next_bit;
          shreg      <= shreg_shifted;
          bit_cnt    <= '0;
          div_cnt    <= '0;
        end
        S_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!seg_clk_q) begin
              seg_clk_q <= 1'b1;
            end else begin
              // Data changes only after the high phase, keeping it stable across the rise.
              seg_clk_q <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state     <= S_LATCH;
                seg_pen_q <= 1'b1;
                done_q    <= 1'b1;
              end else begin
                bit_cnt    <= bit_cnt + 1'b1;
                seg_sout_q <= next_bit;
                shreg      <= shreg_shifted;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          state      <= S_IDLE;
          busy_q     <= 1'b0;
          seg_sout_q <= 1'b0;
          seg_clrn_q <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.seg_clk  = seg_clk_q;
  assign bus.seg_clrn = seg_clrn_q;
  assign bus.seg_sout = seg_sout_q;
  assign bus.seg_pen  = seg_pen_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_sseg_serial_ctrl.sv
// Bench for sseg_serial_ctrl: a default-configured instance driven by a vector
// table, corner sequences and random frames, plus an LSB-first, active-high,
// auto-refresh instance checked against the same frame model.
module tb_sseg_serial_ctrl;

  localparam int DA = 8;
  localparam int CA = 2;
  localparam int DB = 3;
  localparam int CB = 3;
  localparam int AB = 50;
  localparam int LAT_A = 2 + 16 * DA * CA;
  localparam int LAT_B = 2 + 16 * DB * CB;

  localparam logic [7:0] HEX_TBL [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sseg_serial_ctrl_if #(.DIGITS(DA)) a_if ();
  sseg_serial_ctrl_if #(.DIGITS(DB)) b_if ();
  logic [1:0] dbg_a;
  logic [1:0] dbg_b;

  sseg_serial_ctrl #(
    .DIGITS(DA), .CLK_DIV(CA), .MSB_FIRST(1), .SEG_ACTIVE_LOW(1), .AUTO_PERIOD(0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .bus(a_if.slave), .dbg_state(dbg_a)
  );

  sseg_serial_ctrl #(
    .DIGITS(DB), .CLK_DIV(CB), .MSB_FIRST(0), .SEG_ACTIVE_LOW(0), .AUTO_PERIOD(AB)
  ) dut_b (
    .clk(clk), .rst(rst_b), .bus(b_if.slave), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame model: one byte per digit, straight from the display rules.
  function automatic logic [127:0] model_frame(input int nd, input bit act_low,
                                               input logic [63:0] hx, input logic [15:0] pt,
                                               input logic [15:0] le, input logic fl,
                                               input logic rm, input logic [127:0] rs);
    logic [127:0] f;
    logic [7:0]   b;
    logic [7:0]   seg;
    f = '0;
    for (int i = 0; i < nd; i++) begin
      if (le[i] && fl) begin
        b = act_low ? 8'hFF : 8'h00;
      end else if (rm) begin
        b = rs[8*i +: 8];
      end else begin
        seg = HEX_TBL[hx[4*i +: 4]];
        b = {pt[i], seg[6:0]};
        if (act_low) b = ~b;
      end
      f[8*i +: 8] = b;
    end
    return f;
  endfunction

  // ---------------- serial-link monitors ----------------
  logic bits_a[$];
  logic bits_b[$];
  logic prev_clk_a = 1'b0, prev_sout_a = 1'b0;
  logic prev_clk_b = 1'b0;
  int   unstable_a = 0;
  int   done_cnt_a = 0;

  always @(negedge clk) begin
    if (a_if.seg_clk && !prev_clk_a) begin
      bits_a.push_back(a_if.seg_sout);
      if (a_if.seg_sout !== prev_sout_a) unstable_a++;
    end
    if (a_if.done) done_cnt_a++;
    prev_clk_a  = a_if.seg_clk;
    prev_sout_a = a_if.seg_sout;
  end

  always @(negedge clk) begin
    if (b_if.seg_clk && !prev_clk_b) bits_b.push_back(b_if.seg_sout);
    prev_clk_b = b_if.seg_clk;
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic [31:0] hexs;
    logic [7:0]  point;
    logic [7:0]  les;
    logic        flash;
    logic        raw_mode;
    logic [63:0] raw_seg;
    logic [63:0] exp;
  } vec_t;

  int k_a = 0;

  task automatic wait_neg(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic set_a(input vec_t v);
    a_if.hexs     = v.hexs;
    a_if.point    = v.point;
    a_if.les      = v.les;
    a_if.flash    = v.flash;
    a_if.raw_mode = v.raw_mode;
    a_if.raw_seg  = v.raw_seg;
  endtask

  task automatic start_a();
    @(negedge clk);
    bits_a.delete();
    unstable_a = 0;
    a_if.start = 1'b1;
    k_a = cyc;
    @(posedge clk);
    #1 a_if.start = 1'b0;
    @(negedge clk);
    check("load_cycle {busy,clrn,pen,done}",
          {a_if.busy, a_if.seg_clrn, a_if.seg_pen, a_if.done}, 4'b1000);
  endtask

  task automatic finish_a(input logic [63:0] exp, input string nm);
    int t;
    bit got;
    logic [63:0] v;
    t = 0;
    got = 1'b0;
    while (!got && t < 600) begin
      @(negedge clk);
      t++;
      if (a_if.done) got = 1'b1;
    end
    check({nm, " done_seen"}, got, 1);
    if (got) begin
      check({nm, " done_latency"}, cyc - k_a, LAT_A);
      check({nm, " bit_count"}, bits_a.size(), 8 * DA);
      v = '0;
      foreach (bits_a[i]) v = {v[62:0], bits_a[i]};
      check({nm, " frame"}, v, exp);
      check({nm, " data_stable_at_rise"}, unstable_a, 0);
      @(negedge clk);
      check({nm, " idle_after {busy,done,pen,clrn,clk,sout}"},
            {a_if.busy, a_if.done, a_if.seg_pen, a_if.seg_clrn, a_if.seg_clk, a_if.seg_sout},
            6'b001100);
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t vt[7];
  vec_t base;
  vec_t rv;
  int   done_before;
  int   k0;
  int   prev_done;
  logic [127:0] e;
  logic [23:0]  vb;

  initial begin
    vt[0] = '{32'h01234567, 8'h00, 8'h00, 1'b0, 1'b0, 64'h0, 64'hC0F9A4B0999282F8};
    vt[1] = '{32'h01234567, 8'h80, 8'h00, 1'b0, 1'b0, 64'h0, 64'h40F9A4B0999282F8};
    vt[2] = '{32'h01234567, 8'h00, 8'h01, 1'b1, 1'b0, 64'h0, 64'hC0F9A4B0999282FF};
    vt[3] = '{32'h01234567, 8'h00, 8'h01, 1'b0, 1'b0, 64'h0, 64'hC0F9A4B0999282F8};
    vt[4] = '{32'h89ABCDEF, 8'h55, 8'h00, 1'b0, 1'b0, 64'h0, 64'h80108803C621860E};
    vt[5] = '{32'h01234567, 8'h00, 8'h00, 1'b0, 1'b1, 64'hA5A50F0F12345678, 64'hA5A50F0F12345678};
    vt[6] = '{32'h01234567, 8'h00, 8'h10, 1'b1, 1'b1, 64'hA5A50F0F12345678, 64'hA5A50FFF12345678};
    base  = vt[0];

    rst_a = 1'b0;
    rst_b = 1'b0;
    a_if.start = 1'b0;
    set_a(base);
    b_if.start    = 1'b0;
    b_if.flash    = 1'b0;
    b_if.hexs     = '0;
    b_if.les      = '0;
    b_if.point    = '0;
    b_if.raw_mode = 1'b0;
    b_if.raw_seg  = '0;

    // Reset state, then release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {a_if.busy, a_if.done, a_if.seg_pen, a_if.seg_clrn,
                            a_if.seg_clk, a_if.seg_sout, dbg_a}, 8'h00);
    rst_a = 1'b1;
    @(negedge clk);
    check("release {clrn,busy}", {a_if.seg_clrn, a_if.busy}, 2'b10);

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      set_a(vt[i]);
      start_a();
      finish_a(vt[i].exp, $sformatf("vec%0d", i));
    end

    // Snapshot: inputs changed mid-frame do not reach the frame.
    set_a(base);
    start_a();
    fork
      begin
        wait_neg(k_a + 5);
        a_if.hexs = 32'hFFFFFFFF;
      end
      finish_a(base.exp, "snapshot");
    join
    set_a(base);

    // start during SHIFT and during LATCH is ignored; start in the first IDLE cycle works.
    start_a();
    k0 = k_a;
    done_before = done_cnt_a;
    fork
      begin
        wait_neg(k0 + 10);
        a_if.start = 1'b1;
        @(posedge clk);
        #1 a_if.start = 1'b0;
        wait_neg(k0 + LAT_A);
        a_if.start = 1'b1;
        @(posedge clk);
        #1 a_if.start = 1'b0;
      end
      finish_a(base.exp, "ignore_start");
    join
    check("single_done", done_cnt_a - done_before, 1);
    bits_a.delete();
    unstable_a = 0;
    a_if.start = 1'b1;
    k_a = cyc;
    @(posedge clk);
    #1 a_if.start = 1'b0;
    @(negedge clk);
    check("restart_load_at_k+260 {busy,clrn,offset}",
          {a_if.busy, a_if.seg_clrn, 32'(cyc - k0)}, {1'b1, 1'b0, 32'(LAT_A + 2)});
    finish_a(base.exp, "restart");

    // Abort mid-SHIFT with reset.
    start_a();
    wait_neg(k_a + 50);
    rst_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midframe_reset_outputs",
            {a_if.busy, a_if.done, a_if.seg_pen, a_if.seg_clrn, a_if.seg_clk, a_if.seg_sout}, 6'b0);
    end
    rst_a = 1'b1;
    @(negedge clk);
    check("midframe_release {clrn,busy}", {a_if.seg_clrn, a_if.busy}, 2'b10);

    // Random frames against the model.
    for (int n = 0; n < 8; n++) begin
      rv.hexs     = $urandom;
      rv.point    = 8'($urandom_range(0, 255));
      rv.les      = 8'($urandom_range(0, 255));
      rv.flash    = 1'($urandom_range(0, 1));
      rv.raw_mode = ($urandom_range(0, 9) < 3);
      rv.raw_seg  = {$urandom, $urandom};
      rv.exp      = '0;
      exp_q.push_back(model_frame(DA, 1'b1, {32'h0, rv.hexs}, {8'h0, rv.point},
                                  {8'h0, rv.les}, rv.flash, rv.raw_mode, {64'h0, rv.raw_seg}));
      @(negedge clk);
      set_a(rv);
      start_a();
      e = exp_q.pop_front();
      finish_a(e[63:0], $sformatf("rand%0d", n));
    end

    // Auto-refresh instance: LSB first, active-high, no start ever raised.
    b_if.hexs     = 12'($urandom);
    b_if.point    = 3'($urandom_range(0, 7));
    b_if.les      = 3'($urandom_range(0, 7));
    b_if.flash    = 1'($urandom_range(0, 1));
    b_if.raw_mode = 1'b0;
    b_if.raw_seg  = 24'($urandom);
    exp_q.push_back(model_frame(DB, 1'b0, {52'h0, b_if.hexs}, {13'h0, b_if.point},
                                {13'h0, b_if.les}, b_if.flash, b_if.raw_mode, {104'h0, b_if.raw_seg}));
    @(negedge clk);
    rst_b = 1'b1;
    prev_done = 0;
    for (int f = 0; f < 5; f++) begin
      int t;
      bit got;
      t = 0;
      got = 1'b0;
      while (!got && t < 600) begin
        @(negedge clk);
        t++;
        if (b_if.done) got = 1'b1;
      end
      check("auto_done_seen", got, 1);
      if (!got) break;
      if (f > 0) check("auto_done_spacing", cyc - prev_done, AB + LAT_B);
      prev_done = cyc;
      check("auto_bit_count", bits_b.size(), 8 * DB);
      vb = '0;
      foreach (bits_b[i]) if (i < 8 * DB) vb[i] = bits_b[i];
      e = exp_q.pop_front();
      check("auto_frame_lsb_first", vb, e[23:0]);
      bits_b.delete();
      b_if.hexs     = 12'($urandom);
      b_if.point    = 3'($urandom_range(0, 7));
      b_if.les      = 3'($urandom_range(0, 7));
      b_if.flash    = 1'($urandom_range(0, 1));
      b_if.raw_mode = 1'($urandom_range(0, 1));
      b_if.raw_seg  = 24'($urandom);
      exp_q.push_back(model_frame(DB, 1'b0, {52'h0, b_if.hexs}, {13'h0, b_if.point},
                                  {13'h0, b_if.les}, b_if.flash, b_if.raw_mode, {104'h0, b_if.raw_seg}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog in case a wait above never resolves.
  initial begin
    #(10 * 60000);
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
